decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ZERO_X0_WRITE, default 1, meaning: force wrt_en=0 when decoded rd is x0.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream instruction word valid.
REQ-005 in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 in_instr  input  32  RV32I instruction word.
REQ-007 in_pc  input  32  PC of in_instr.
REQ-008 flush  input  1  discard all held instructions (branch redirect).
REQ-009 out_valid  output  1  decoded bundle valid.
REQ-010 out_ready  input  1  downstream (register file / execute) accepts bundle.
REQ-011 oprs1, oprs2, oprd  output  5 each  source and destination register addresses for the register file.
REQ-012 wrt_en  output  1  instruction writes oprd.
REQ-013 imm  output  32  sign-extended immediate.
REQ-014 alu_op  output  4  ALU operation code.
REQ-015 op_class  output  3  instruction class.
REQ-016 illegal  output  1  unsupported or invalid encoding.
REQ-017 out_pc  output  32  PC carried with the bundle.

Function
REQ-018 Transfer in: in_valid&&in_ready; transfer out: out_valid&&out_ready.
REQ-019 Storage: one output register (main) plus one skid register; decode is combinational on in_instr, and the result is registered.
REQ-020 Latency: a bundle accepted in cycle N is presented with out_valid=1 in cycle N+1 when main is empty or draining.
REQ-021 in_ready = !skid_valid, registered; no combinational path from out_ready to in_ready.
REQ-022 Accept with main full and not draining: write the bundle to skid; on the next out transfer, skid moves to main.
REQ-023 Ordering: bundles leave in acceptance order; none lost or duplicated under any out_ready pattern.
REQ-024 While out_valid=1 and out_ready=0, all outputs hold stable.
REQ-025 Opcodes decoded: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, FENCE 0001111, SYSTEM 1110011.
REQ-026 Immediate formats: I, S, B, U, J per RV32I, bit 31 sign-extended; R-type imm=0.
REQ-027 Unused oprs1/oprs2/oprd fields output 0 (e.g. oprs2=0 for I-type, oprd=0 for S/B).
REQ-028 wrt_en=1 only for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP; gated by REQ-001.
REQ-029 alu_op: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10. Loads, stores, AUIPC and jumps use ADD; branches use SUB.
REQ-030 op_class: ALU 0, LOAD 1, STORE 2, BRANCH 3, JUMP 4, SYS 5 (FENCE/SYSTEM), ILLEGAL 7.
REQ-031 Unknown opcode, bad funct3/funct7 (e.g. OP with funct7 not 0000000/0100000, SLLI with funct7!=0): illegal=1, op_class=7, wrt_en=0, bundle still passed downstream.
REQ-032 flush: main and skid valid clear at the next edge; flush has priority over a same-cycle input transfer, which is dropped; in_ready=1 the cycle after.

Reset
REQ-033 rst asserted: out_valid=0, skid_valid=0, in_ready=1 immediately, asynchronously; data outputs 0.
REQ-034 rst mid-transfer discards all held bundles; the first acceptance occurs on the first edge after rst deasserts.

Verification
REQ-035 in_instr=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle oprd=1, oprs1=0, imm=5, wrt_en=1, alu_op=0, op_class=0.
REQ-036 in_instr=0xFE21AE23 (sw x2,-4(x3)) -> oprs1=3, oprs2=2, oprd=0, imm=0xFFFFFFFC, wrt_en=0, op_class=2.
REQ-037 in_instr=0x00000013 (addi x0,x0,0) -> wrt_en=0; in_instr=0x00000000 -> illegal=1, op_class=7.
REQ-038 Three back-to-back instrs with out_ready=0 -> first two held, in_ready=0 after second; raise out_ready -> three bundles exit in order, no loss.
REQ-039 flush with main and skid full plus in_valid=1 -> out_valid=0 next cycle, input dropped, in_ready=1.
REQ-040 rst pulsed between edges while out_valid=1 -> out_valid=0 before next edge; recovers on the following accept.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word, registered into a
// main output register backed by a one-entry skid register so in_ready is a flop.
module decode_stage #(
  parameter int ZERO_X0_WRITE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  oprs1,
  output logic [4:0]  oprs2,
  output logic [4:0]  oprd,
  output logic        wrt_en,
  output logic [31:0] imm,
  output logic [3:0]  alu_op,
  output logic [2:0]  op_class,
  output logic        illegal,
  output logic [31:0] out_pc
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JUMP   = 3'd4;
  localparam logic [2:0] CLS_SYS    = 3'd5;
  localparam logic [2:0] CLS_ILL    = 3'd7;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [2:0]  cls;
    logic        ill;
    logic [31:0] pc;
  } bundle_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        bad;
  bundle_t     dec;

  assign opcode = in_instr[6:0];
  assign rd_f   = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'h000};
  assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.alu = ALU_ADD;
    dec.cls = CLS_ALU;
    bad     = 1'b0;
    unique case (opcode)
      OPC_LUI: begin
        dec.rd = rd_f; dec.we = 1'b1; dec.imm = imm_u; dec.alu = ALU_PASSB;
      end
      OPC_AUIPC: begin
        dec.rd = rd_f; dec.we = 1'b1; dec.imm = imm_u;
      end
      OPC_JAL: begin
        dec.rd = rd_f; dec.we = 1'b1; dec.imm = imm_j; dec.cls = CLS_JUMP;
      end
      OPC_JALR: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.we = 1'b1; dec.imm = imm_i; dec.cls = CLS_JUMP;
        bad = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.imm = imm_b; dec.alu = ALU_SUB; dec.cls = CLS_BRANCH;
        bad = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.we = 1'b1; dec.imm = imm_i; dec.cls = CLS_LOAD;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.imm = imm_s; dec.cls = CLS_STORE;
        bad = (funct3 > 3'b010);
      end
      OPC_OPIMM: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.we = 1'b1; dec.imm = imm_i;
        unique case (funct3)
          3'b000: dec.alu = ALU_ADD;
          3'b001: begin dec.alu = ALU_SLL; bad = (funct7 != 7'b0000000); end
          3'b010: dec.alu = ALU_SLT;
          3'b011: dec.alu = ALU_SLTU;
          3'b100: dec.alu = ALU_XOR;
          3'b101: begin
            dec.alu = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
          3'b110: dec.alu = ALU_OR;
          default: dec.alu = ALU_AND;
        endcase
      end
      OPC_OP: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.we = 1'b1;
        unique case (funct3)
          3'b000: dec.alu = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001: dec.alu = ALU_SLL;
          3'b010: dec.alu = ALU_SLT;
          3'b011: dec.alu = ALU_SLTU;
          3'b100: dec.alu = ALU_XOR;
          3'b101: dec.alu = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: dec.alu = ALU_OR;
          default: dec.alu = ALU_AND;
        endcase
        // The alternate funct7 only exists for SUB and SRA.
        bad = !((funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_FENCE: begin
        dec.cls = CLS_SYS;
        bad = (funct3 != 3'b000);
      end
      OPC_SYSTEM: begin
        dec.cls = CLS_SYS; dec.imm = imm_i;
        bad = (funct3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec     = '0;
      dec.pc  = in_pc;
      dec.cls = CLS_ILL;
      dec.ill = 1'b1;
    end
    if ((ZERO_X0_WRITE != 0) && (dec.rd == 5'd0)) dec.we = 1'b0;
  end

  // Handshake: a transfer happens on any edge where valid && ready are both high;
  // ready never depends combinationally on valid, and valid bundles hold until taken.
  bundle_t main_q, main_d, skid_q, skid_d;
  logic    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic    in_xfer;

  assign in_ready = !skid_valid_q;
  assign in_xfer  = in_valid && !skid_valid_q;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      // Skid only fills while main is full, so it always refills main first.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign oprs1     = main_q.rs1;
  assign oprs2     = main_q.rs2;
  assign oprd      = main_q.rd;
  assign wrt_en    = main_q.we;
  assign imm       = main_q.imm;
  assign alu_op    = main_q.alu;
  assign op_class  = main_q.cls;
  assign illegal   = main_q.ill;
  assign out_pc    = main_q.pc;

endmodule
